// File: rtl/mem_rw_requester.sv
// mem_rw_requester
// Converts byte-addressed valid/ready requests from the bus side into
// word-indexed accesses on the memory model's single-port read/write
// interface. Only one request is outstanding at a time, and each request gets
// exactly one response.
// Optional build macro MEM_RW_REQUESTER_STATS_EN adds saturating 32-bit
// response counters (stat_reads, stat_writes, stat_errs).
module mem_rw_requester #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter logic [63:0] RAM_BYTES = 64'd1610612736,
    parameter int          ID_W      = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    // bus-side request channel
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [63:0]     req_addr,
    input  logic [63:0]     req_wdata,
    input  logic [7:0]      req_wstrb,
    input  logic [ID_W-1:0] req_id,
    // bus-side response channel
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_rdata,
    output logic [ID_W-1:0] resp_id,
    output logic            resp_err,
    // memory model interface
    output logic            r_enable,
    output logic [63:0]     r_index,
    input  logic [63:0]     r_data,
    output logic            w_enable,
    output logic [63:0]     w_index,
    output logic [63:0]     w_data,
    output logic [63:0]     w_mask,
    output logic            enable
`ifdef MEM_RW_REQUESTER_STATS_EN
    ,
    output logic [31:0]     stat_reads,
    output logic [31:0]     stat_writes,
    output logic [31:0]     stat_errs
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // One past the last byte backed by memory.
    localparam logic [63:0] END_ADDR = BASE_ADDR + RAM_BYTES;

    state_t      r_state;
    logic        r_write;

    logic        w_accept;
    logic        w_err;
    logic [63:0] w_idx;
    logic [63:0] w_bitmask;

    // Byte strobes to a per-bit mask: bit 8k+j follows strobe k.
    function automatic logic [63:0] expand_strb(input logic [7:0] strb);
        logic [63:0] res;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            res[8*k +: 8] = {8{strb[k]}};
        end
        return res;
    endfunction

    // Counters stop at all-ones rather than wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign req_ready = (r_state == S_IDLE) && enable;
    assign w_accept  = req_valid && req_ready;
    assign w_err     = (req_addr[2:0] != 3'd0) ||
                       (req_addr < BASE_ADDR)  ||
                       (req_addr >= END_ADDR);
    assign w_idx     = (req_addr - BASE_ADDR) >> 3;
    assign w_bitmask = expand_strb(req_wstrb);

    // Memory enable rises on the first clock edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
        end else begin
            enable <= 1'b1;
        end
    end

    // Request FSM. All strobes and response fields are registered; the memory
    // index/data/mask only change when entering ISSUE, so they hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            r_enable   <= 1'b0;
            r_index    <= '0;
            w_enable   <= 1'b0;
            w_index    <= '0;
            w_data     <= '0;
            w_mask     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        resp_id    <= req_id;
                        resp_err   <= w_err;
                        resp_rdata <= '0;
                        if (w_err) begin
                            // Address errors skip the memory entirely.
                            resp_valid <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                            if (req_write) begin
                                w_enable <= 1'b1;
                                w_index  <= w_idx;
                                w_data   <= req_wdata;
                                w_mask   <= w_bitmask;
                            end else begin
                                r_enable <= 1'b1;
                                r_index  <= w_idx;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    r_enable <= 1'b0;
                    w_enable <= 1'b0;
                    if (r_write) begin
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Memory returns read data one cycle after the strobe.
                    resp_rdata <= r_data;
                    resp_valid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_RW_REQUESTER_STATS_EN
    // Count completed responses by class; errored requests count only as errors.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errs   <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_err) begin
                stat_errs <= sat_inc(stat_errs);
            end else if (r_write) begin
                stat_writes <= sat_inc(stat_writes);
            end else begin
                stat_reads <= sat_inc(stat_reads);
            end
        end
    end
`else
    // Without the counters the saturating helper has no caller.
    logic [31:0] w_unused_sat;
    assign w_unused_sat = sat_inc(32'd0);
`endif

endmodule

// File: doc/mem_rw_requester.md
Name: mem_rw_requester

Overview:
- Initiator for the simulation memory model's single-port read/write interface (r_enable/r_index/r_data, w_enable/w_index/w_data/w_mask, enable).
- Accepts byte-addressed valid/ready requests from a bus-side master and converts them to word-indexed memory accesses. Returns one response per request.
- One outstanding request at a time. Sits between the SoC memory port adapter and the memory model in the simulation top.

Parameters:
- BASE_ADDR, 64'h8000_0000, byte address that maps to memory word 0
- RAM_BYTES, 64'd1610612736 (1536 MiB), size of the backing memory in bytes
- ID_W, 4, width of the request/response tag

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  64  byte address
- req_wdata  in  64  write data
- req_wstrb  in  8  byte strobes
- req_id  in  ID_W  request tag
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&&ready
- resp_rdata  out  64  read data (0 for writes and errors)
- resp_id  out  ID_W  echoed tag
- resp_err  out  1  address error
- r_enable  out  1  memory read strobe
- r_index  out  64  memory read word index
- r_data  in  64  memory read data, valid the cycle after r_enable
- w_enable  out  1  memory write strobe
- w_index  out  64  memory write word index
- w_data  out  64  memory write data
- w_mask  out  64  memory bit mask
- enable  out  1  memory enable

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including enable, req_ready, resp_* and all memory strobes/indices.
  - Any request in flight is dropped without a response.
- enable: registered; 1 from the first clock edge after reset release.
- req_ready = (state==IDLE) && enable. Requests are never accepted in any other state.
- On acceptance, latch write, addr, wdata, wstrb and id.
- err = (addr[2:0]!=0) || addr<BASE_ADDR || addr>=BASE_ADDR+RAM_BYTES. All compares are unsigned 64-bit.
- index = (addr-BASE_ADDR)>>3, zero-extended to 64 bits.
- mask = byte-wise expansion of wstrb: bit 8k+j = wstrb[k].
- State machine:
  - IDLE: on accept, go to RESP if err, else ISSUE.
  - ISSUE: exactly one cycle.
    - Read: r_enable=1, r_index=index, then go to WAIT.
    - Write: w_enable=1, w_index=index, w_data=wdata, w_mask=mask, then go to RESP.
    - wstrb=0 still issues the write (mask=0, memory unchanged).
  - WAIT (read only): r_data is valid this cycle. Capture it into resp_rdata at the end of the cycle, then go to RESP.
  - RESP: resp_valid=1 with resp_id, resp_err and resp_rdata held stable. Return to IDLE on resp_ready. resp_valid deasserts the cycle after the handshake.
- Strobes: r_enable and w_enable are high only in ISSUE, never simultaneously.
- Index/data/mask hold: r_index, w_index, w_data and w_mask hold their last value outside ISSUE.
- Latency, counted from the accept edge:
  - read: resp_valid in cycle +3
  - write: resp_valid in cycle +2
  - error: resp_valid in cycle +1
- Error responses: no memory strobe is asserted; resp_rdata=0, resp_err=1.
- Ready timing: req_ready is low throughout ISSUE, WAIT and RESP. Because the RESP handshake moves the state to IDLE, req_ready can rise at the earliest in the cycle after the response handshake.
- resp_ready held 0: the block stalls in RESP indefinitely; no timeout.

Optional Feature:
- Macro: MEM_RW_REQUESTER_STATS_EN.
- Defined: adds three output ports, each 32 bits wide: stat_reads, stat_writes, stat_errs.
  - Each increments by 1 on the RESP handshake of the corresponding request class; a successful read counts as a read and a successful write as a write.
  - Errored requests count only in stat_errs.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and the counter logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Write addr=0x8000_0010, wdata=0x1122_3344_5566_7788, wstrb=0xFF; then read the same address.
  -> write: w_enable one cycle, w_index=2, w_mask=all ones, resp_err=0.
  -> read: r_enable one cycle, r_index=2, resp_rdata=0x1122_3344_5566_7788 at accept+3.
- Write wstrb=0x0F, wdata=0xAAAA_AAAA_BBBB_BBBB to a word holding 0x1111_1111_2222_2222.
  -> w_mask=0x0000_0000_FFFF_FFFF; a subsequent read returns 0x1111_1111_BBBB_BBBB.
- Read addr=0x7FFF_FFF8, addr=BASE_ADDR+RAM_BYTES and addr=0x8000_0004.
  -> each gives resp_err=1, resp_rdata=0, resp_valid at accept+1, no r_enable/w_enable pulse.
- Read with resp_ready held 0 for 5 cycles.
  -> resp_valid, resp_id and resp_rdata stable throughout; req_ready=0 throughout.
  -> after the handshake, resp_valid drops and the next request is accepted.
- Assert reset_n=0 during WAIT of a read with id=5.
  -> all outputs 0 immediately; no response with id=5 after release.
  -> enable returns to 1 one cycle after release.
- With MEM_RW_REQUESTER_STATS_EN: 3 reads, 2 writes, 1 error.
  -> stat_reads=3, stat_writes=2, stat_errs=1.
  -> without the macro, the same sequence gives identical responses.
